// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle barrel-free shifter (SLL/SRL/SRA/ROR).
// Each operation is accepted in IDLE. It then shifts the result register
// one bit per SHIFT cycle, pulses done for one cycle in DONE, and returns
// to IDLE.
// Optional build macro SERIAL_SHIFTER_FAST4_EN: each SHIFT cycle moves up to
// four bits (min(4, count)), which shortens latency. Final results are unchanged.
module serial_shifter #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] amt_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [AMT_W-1:0]  count_q;
    logic [DATA_W-1:0] result_q;
    logic              busy_q;
    logic              done_q;

    logic [AMT_W-1:0]  step_d;
    logic [AMT_W-1:0]  rot_left_d;
    logic [DATA_W-1:0] shifted_d;
    logic [AMT_W-1:0]  amt_d;

    // Only the low shift-count bits matter; the rest of amt_in is dropped here.
    logic unused_amt_bits;
    assign unused_amt_bits = ^amt_in[DATA_W-1:AMT_W];
    assign amt_d           = amt_in[AMT_W-1:0];

    // Bits moved this SHIFT cycle: 1 normally, min(4, count) in the fast build.
    always_comb begin
`ifdef SERIAL_SHIFTER_FAST4_EN
        step_d = (count_q >= AMT_W'(4)) ? AMT_W'(4) : count_q;
`else
        step_d = AMT_W'(1);
`endif
    end

    // Next result value for one SHIFT cycle.
    // ROR uses a right shift ORed with a left shift by (DATA_W - step).
    // The modulo-DATA_W wrap of the left amount makes step=0 a harmless no-op.
    always_comb begin
        rot_left_d = AMT_W'(0) - step_d;
        case (op_q)
            OP_SLL:  shifted_d = result_q << step_d;
            OP_SRL:  shifted_d = result_q >> step_d;
            OP_SRA:  shifted_d = $unsigned($signed(result_q) >>> step_d);
            default: shifted_d = (result_q >> step_d) | (result_q << rot_left_d);
        endcase
    end

    // Control FSM with registered busy/done and the working result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        result_q <= data_in;
                        op_q     <= op;
                        count_q  <= amt_d;
                        busy_q   <= 1'b1;
                        if (amt_d != '0) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shifted_d;
                    count_q  <= count_q - step_d;
                    if (count_q == step_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter.
// Expected results and latencies are queued when an operation is issued and
// popped when the DUT pulses done. Define SERIAL_SHIFTER_FAST4_EN for both
// the bench and the design to check the fast build.
module tb_serial_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [31:0] amt_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    serial_shifter #(.DATA_W(32), .AMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amt_in  (amt_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Reference: whole-amount shift in one step.
    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return $unsigned($signed(d) >>> n);
            default: begin
                dd = {d, d} >> n;
                return dd[31:0];
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the cycle that shows done.
    function automatic int exp_lat(input int n);
`ifdef SERIAL_SHIFTER_FAST4_EN
        return (n + 3) / 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start, queue the expectation, then scramble the inputs.
    task automatic issue_op(input logic [1:0] o, input logic [31:0] d, input logic [31:0] a);
        exp_t e;
        op      = o;
        data_in = d;
        amt_in  = a;
        start   = 1'b1;
        e.res   = model_res(o, d, int'(a[4:0]));
        e.lat   = exp_lat(int'(a[4:0]));
        sb_q.push_back(e);
        tick();
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = $urandom;
        amt_in  = $urandom;
    endtask

    // Bounded wait for done; lat counts cycles since the accepting edge.
    task automatic wait_done(input int budget, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 1;
        while (!seen && lat <= budget) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   bad;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        #2 rst = 1'b0;
        issue_op(2'b00, 32'h0000_00A5, 32'd10);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        // Assert reset between edges; the outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", result); end
        e = sb_q.pop_front();
        #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
        $display("txn reset abort of pending op (expected result %h discarded)", e.res);
    endtask

    task automatic test_sll();
        exp_t e;
        bit   seen;
        int   lat;
        issue_op(2'b00, 32'h0000_0001, 32'h0000_0004);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sll_busy: got %b want 1", busy); end
        wait_done(40, seen, lat);
        e = sb_q.pop_front();
        checks++; if (!seen) begin errors++; $display("FAIL sll_timeout: done not seen in 40 cycles"); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL sll_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL sll_result: got %h want %h", result, e.res); end
        $display("txn SLL result=%h lat=%0d", result, lat);
        tick();
        tick();
        checks++; if (result !== e.res) begin errors++; $display("FAIL sll_hold: got %h want %h", result, e.res); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL sll_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_sra();
        exp_t e;
        bit   seen;
        int   lat;
        issue_op(2'b10, 32'h8000_0000, 32'hFFFF_FFE3);
        wait_done(40, seen, lat);
        e = sb_q.pop_front();
        checks++; if (!seen) begin errors++; $display("FAIL sra_timeout: done not seen in 40 cycles"); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL sra_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (result !== 32'hF000_0000) begin errors++; $display("FAIL sra_result: got %h want %h", result, 32'hF000_0000); end
        $display("txn SRA result=%h lat=%0d", result, lat);
        tick();
    endtask

    task automatic test_ror();
        exp_t e;
        bit   seen;
        int   lat;
        int   early;
        int   bad;
        issue_op(2'b11, 32'h0000_000F, 32'd31);
        // Start pulses mid-operation carry different data; they must be ignored.
        early = 0;
        start = 1'b1; op = 2'b00; data_in = 32'hFFFF_FFFF; amt_in = 32'd1;
        tick(); if (done === 1'b1) early++;
        start = 1'b0;
        tick(); if (done === 1'b1) early++;
        start = 1'b1;
        tick(); if (done === 1'b1) early++;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || early != 0) begin errors++; $display("FAIL ror_busy: got busy=%b early_done=%0d want 1 0", busy, early); end
        wait_done(40, seen, lat);
        lat += 3;
        e = sb_q.pop_front();
        checks++; if (!seen) begin errors++; $display("FAIL ror_timeout: done not seen in 43 cycles"); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL ror_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (result !== 32'h0000_001E) begin errors++; $display("FAIL ror_result: got %h want %h", result, 32'h0000_001E); end
        $display("txn ROR result=%h lat=%0d", result, lat);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ror_no_queue: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   seen;
        int   lat;
        op = 2'b01; data_in = 32'hDEAD_BEEF; amt_in = 32'd0; start = 1'b1;
        e.res = model_res(2'b01, 32'hDEAD_BEEF, 0);
        e.lat = exp_lat(0);
        sb_q.push_back(e);
        tick();
        // start stays high; present the second operation straight away.
        op = 2'b00; data_in = 32'h0000_0003; amt_in = 32'd2;
        e.res = model_res(2'b00, 32'h0000_0003, 2);
        e.lat = exp_lat(2);
        sb_q.push_back(e);
        wait_done(1, seen, lat);
        e = sb_q.pop_front();
        checks++; if (!seen || lat !== e.lat) begin errors++; $display("FAIL b2b_zero_latency: got seen=%b lat=%0d want 1 %0d", seen, lat, e.lat); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_zero_result: got %h want %h", result, e.res); end
        $display("txn SRL amt0 result=%h lat=%0d", result, lat);
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(40, seen, lat);
        e = sb_q.pop_front();
        checks++; if (!seen || lat !== e.lat) begin errors++; $display("FAIL b2b_second_latency: got seen=%b lat=%0d want 1 %0d", seen, lat, e.lat); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_second_result: got %h want %h", result, e.res); end
        $display("txn SLL b2b result=%h lat=%0d", result, lat);
        tick();
    endtask

    task automatic test_abort();
        exp_t e;
        bit   seen;
        int   lat;
        issue_op(2'b01, 32'h1234_5678, 32'd20);
        tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_clear: got busy=%b done=%b want 0 0", busy, done); end
        e = sb_q.pop_front();
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
        op = 2'b01; data_in = 32'h0000_0100; amt_in = 32'd8; start = 1'b1;
        e.res = model_res(2'b01, 32'h0000_0100, 8);
        e.lat = exp_lat(8);
        sb_q.push_back(e);
        #2 rst = 1'b0;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_first_accept: got busy=%b want 1", busy); end
        wait_done(40, seen, lat);
        e = sb_q.pop_front();
        checks++; if (!seen || lat !== e.lat) begin errors++; $display("FAIL abort_next_latency: got seen=%b lat=%0d want 1 %0d", seen, lat, e.lat); end
        checks++; if (result !== 32'h0000_0001) begin errors++; $display("FAIL abort_next_result: got %h want %h", result, 32'h0000_0001); end
        $display("txn SRL after abort result=%h lat=%0d", result, lat);
        tick();
    endtask

    task automatic test_random();
        exp_t        e;
        bit          seen;
        int          lat;
        logic [1:0]  o;
        logic [31:0] d;
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom);
            d = $urandom;
            a = $urandom;
            issue_op(o, d, a);
            wait_done(40, seen, lat);
            e = sb_q.pop_front();
            checks++; if (!seen || lat !== e.lat) begin errors++; $display("FAIL rand%0d_latency: got seen=%b lat=%0d want 1 %0d", i, seen, lat, e.lat); end
            checks++; if (result !== e.res) begin errors++; $display("FAIL rand%0d_result: op=%0d data=%h amt=%0d got %h want %h", i, o, d, a[4:0], result, e.res); end
            $display("txn rand op=%0d data=%h amt=%0d result=%h lat=%0d", o, d, a[4:0], result, lat);
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = 32'h0;
        amt_in  = 32'h0;
        test_reset();
        test_sll();
        test_sra();
        test_ror();
        test_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
